msg_link_arbiter: RTL and testbench

- Sequences a single shared message channel between Machine A and Machine B.
- Each side requests to send a MSG_W-bit message. The arbiter grants one sender at a time, round-robin.
- The granted message is latched and presented to the opposite machine with valid/ack. Completion (done) or timeout (err) is reported back to the sender.
- Per-direction delivery counters are kept for status.

---
 rtl/msg_link_arbiter.sv | 154 +++++++++++++++
 tb/tb_msg_link_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/msg_link_arbiter.sv
// Round-robin arbiter for one shared message channel between machines A and B.
// A granted message is latched, offered to the opposite side with valid/ack, and the outcome is reported back.
module msg_link_arbiter #(
    parameter int MSG_W   = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic [MSG_W-1:0] a_msg,
    output logic             a_gnt,
    output logic             a_done,
    output logic             a_err,
    input  logic             b_req,
    input  logic [MSG_W-1:0] b_msg,
    output logic             b_gnt,
    output logic             b_done,
    output logic             b_err,
    output logic             to_b_valid,
    output logic [MSG_W-1:0] to_b_msg,
    input  logic             to_b_ack,
    output logic             to_a_valid,
    output logic [MSG_W-1:0] to_a_msg,
    input  logic             to_a_ack,
    output logic             busy,
    output logic [CNT_W-1:0] a2b_count,
    output logic [CNT_W-1:0] b2a_count
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

    state_t           state, state_nx;
    logic             src, src_nx;   // 0 = A sending, 1 = B sending
    logic             ptr, ptr_nx;   // side preferred on contention
    logic [MSG_W-1:0] hold, hold_nx;
    logic [WCW-1:0]   wcnt, wcnt_nx;
    logic [CNT_W-1:0] a2b_nx, b2a_nx;
    logic             a_gnt_nx, a_done_nx, a_err_nx;
    logic             b_gnt_nx, b_done_nx, b_err_nx;
    logic             to_a_valid_nx, to_b_valid_nx, busy_nx;
    logic [MSG_W-1:0] to_a_msg_nx, to_b_msg_nx;
    logic             win_b, ack;

    assign win_b = b_req && (!a_req || ptr);
    assign ack   = src ? to_a_ack : to_b_ack;

    always_comb begin
        state_nx      = state;
        src_nx        = src;
        ptr_nx        = ptr;
        hold_nx       = hold;
        wcnt_nx       = wcnt;
        a2b_nx        = a2b_count;
        b2a_nx        = b2a_count;
        a_gnt_nx      = 1'b0;
        a_done_nx     = 1'b0;
        a_err_nx      = 1'b0;
        b_gnt_nx      = 1'b0;
        b_done_nx     = 1'b0;
        b_err_nx      = 1'b0;
        to_a_valid_nx = 1'b0;
        to_b_valid_nx = 1'b0;
        to_a_msg_nx   = '0;
        to_b_msg_nx   = '0;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    state_nx      = SEND;
                    src_nx        = win_b;
                    hold_nx       = win_b ? b_msg : a_msg;
                    wcnt_nx       = '0;
                    a_gnt_nx      = !win_b;
                    b_gnt_nx      = win_b;
                    to_a_valid_nx = win_b;
                    to_b_valid_nx = !win_b;
                    to_a_msg_nx   = win_b ? b_msg : '0;
                    to_b_msg_nx   = win_b ? '0 : a_msg;
                end
            end
            SEND: begin
                if (ack) begin
                    // ack beats a timeout landing on the same cycle
                    state_nx  = FIN;
                    ptr_nx    = !src;
                    a_done_nx = !src;
                    b_done_nx = src;
                    if (src) b2a_nx = b2a_count + 1'b1;
                    else     a2b_nx = a2b_count + 1'b1;
                end else if (wcnt == WLAST) begin
                    state_nx = FIN;
                    ptr_nx   = !src;
                    a_err_nx = !src;
                    b_err_nx = src;
                end else begin
                    wcnt_nx       = wcnt + 1'b1;
                    to_a_valid_nx = src;
                    to_b_valid_nx = !src;
                    to_a_msg_nx   = src ? hold : '0;
                    to_b_msg_nx   = src ? '0 : hold;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            src        <= 1'b0;
            ptr        <= 1'b0;
            hold       <= '0;
            wcnt       <= '0;
            a2b_count  <= '0;
            b2a_count  <= '0;
            a_gnt      <= 1'b0;
            a_done     <= 1'b0;
            a_err      <= 1'b0;
            b_gnt      <= 1'b0;
            b_done     <= 1'b0;
            b_err      <= 1'b0;
            to_a_valid <= 1'b0;
            to_b_valid <= 1'b0;
            to_a_msg   <= '0;
            to_b_msg   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            src        <= src_nx;
            ptr        <= ptr_nx;
            hold       <= hold_nx;
            wcnt       <= wcnt_nx;
            a2b_count  <= a2b_nx;
            b2a_count  <= b2a_nx;
            a_gnt      <= a_gnt_nx;
            a_done     <= a_done_nx;
            a_err      <= a_err_nx;
            b_gnt      <= b_gnt_nx;
            b_done     <= b_done_nx;
            b_err      <= b_err_nx;
            to_a_valid <= to_a_valid_nx;
            to_b_valid <= to_b_valid_nx;
            to_a_msg   <= to_a_msg_nx;
            to_b_msg   <= to_b_msg_nx;
            busy       <= busy_nx;
        end
    end

endmodule

// File: tb/tb_msg_link_arbiter.sv
// Directed bench for msg_link_arbiter: per-cycle vector table plus hand sequences
// for timeout, last-cycle ack, reset during SEND and counter wrap.
module tb_msg_link_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, b_req, to_a_ack, to_b_ack;
    logic [31:0] a_msg, b_msg;
    logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
    logic        to_a_valid, to_b_valid, busy;
    logic [31:0] to_a_msg, to_b_msg;
    logic [15:0] a2b_count, b2a_count;

    // narrow-counter instance for the wrap check
    logic        w_a_req, w_b_req, w_to_a_ack, w_to_b_ack;
    logic [7:0]  w_a_msg, w_b_msg, w_to_a_msg, w_to_b_msg;
    logic        w_a_gnt, w_a_done, w_a_err, w_b_gnt, w_b_done, w_b_err;
    logic        w_to_a_valid, w_to_b_valid, w_busy;
    logic [1:0]  w_a2b, w_b2a;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msg_link_arbiter #(.MSG_W(32), .TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_msg(a_msg), .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err),
        .b_req(b_req), .b_msg(b_msg), .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err),
        .to_b_valid(to_b_valid), .to_b_msg(to_b_msg), .to_b_ack(to_b_ack),
        .to_a_valid(to_a_valid), .to_a_msg(to_a_msg), .to_a_ack(to_a_ack),
        .busy(busy), .a2b_count(a2b_count), .b2a_count(b2a_count)
    );

    msg_link_arbiter #(.MSG_W(8), .TIMEOUT(4), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .a_req(w_a_req), .a_msg(w_a_msg), .a_gnt(w_a_gnt), .a_done(w_a_done), .a_err(w_a_err),
        .b_req(w_b_req), .b_msg(w_b_msg), .b_gnt(w_b_gnt), .b_done(w_b_done), .b_err(w_b_err),
        .to_b_valid(w_to_b_valid), .to_b_msg(w_to_b_msg), .to_b_ack(w_to_b_ack),
        .to_a_valid(w_to_a_valid), .to_a_msg(w_to_a_msg), .to_a_ack(w_to_a_ack),
        .busy(w_busy), .a2b_count(w_a2b), .b2a_count(w_b2a)
    );

    typedef struct packed {
        logic [5:0]  pulses;   // a_gnt a_done a_err b_gnt b_done b_err
        logic        av;
        logic [31:0] am;
        logic        bv;
        logic [31:0] bm;
        logic        busy;
        logic [15:0] a2b;
        logic [15:0] b2a;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        areq;
        logic [31:0] amsg;
        logic        breq;
        logic [31:0] bmsg;
        logic        aack;
        logic        back;
        out_t        exp;
    } vec_t;

    vec_t vq[$];

    function automatic out_t ex(input logic [5:0] p, input logic av, input logic [31:0] am,
                                input logic bv, input logic [31:0] bm, input logic bz,
                                input logic [15:0] ab, input logic [15:0] ba);
        out_t o;
        o = '{pulses: p, av: av, am: am, bv: bv, bm: bm, busy: bz, a2b: ab, b2a: ba};
        return o;
    endfunction

    function automatic vec_t vin(input logic rst, input logic ar, input logic [31:0] am,
                                 input logic br, input logic [31:0] bm,
                                 input logic aa, input logic ba, input out_t e);
        vec_t v;
        v = '{rst: rst, areq: ar, amsg: am, breq: br, bmsg: bm, aack: aa, back: ba, exp: e};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; to_a_ack = 1'b0; to_b_ack = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    function automatic out_t cur();
        out_t o;
        o = '{pulses: {a_gnt, a_done, a_err, b_gnt, b_done, b_err}, av: to_a_valid, am: to_a_msg,
              bv: to_b_valid, bm: to_b_msg, busy: busy, a2b: a2b_count, b2a: b2a_count};
        return o;
    endfunction

    initial begin
        int vc, ec, dc, bad, pulses, k;
        logic [1:0] wexp;
        rst_n = 1'b0; a_req = 0; b_req = 0; a_msg = 0; b_msg = 0; to_a_ack = 0; to_b_ack = 0;
        w_a_req = 0; w_b_req = 0; w_a_msg = 8'h5a; w_b_msg = 0; w_to_a_ack = 0; w_to_b_ack = 1;

        // A-only send, ack in 3rd SEND cycle; stray to_a_ack must be ignored
        vq.push_back(vin(0, 0, 0,   0, 0, 0, 0, ex(6'b000000, 0, 0, 0, 0,   0, 0, 0)));
        vq.push_back(vin(1, 1, 100, 0, 0, 0, 0, ex(6'b100000, 0, 0, 1, 100, 1, 0, 0)));
        vq.push_back(vin(1, 1, 100, 0, 0, 1, 0, ex(6'b000000, 0, 0, 1, 100, 1, 0, 0)));
        vq.push_back(vin(1, 1, 100, 0, 0, 1, 0, ex(6'b000000, 0, 0, 1, 100, 1, 0, 0)));
        vq.push_back(vin(1, 1, 100, 0, 0, 0, 1, ex(6'b010000, 0, 0, 0, 0,   1, 1, 0)));
        vq.push_back(vin(1, 0, 100, 0, 0, 0, 0, ex(6'b000000, 0, 0, 0, 0,   0, 1, 0)));
        vq.push_back(vin(1, 0, 100, 0, 0, 0, 0, ex(6'b000000, 0, 0, 0, 0,   0, 1, 0)));
        vq.push_back(vin(0, 0, 0,   0, 0, 0, 0, ex(6'b000000, 0, 0, 0, 0,   0, 0, 0)));
        // contention from reset, acks high: A,B,A,B every 3 cycles
        vq.push_back(vin(1, 1, 1, 1, 2, 1, 1, ex(6'b100000, 0, 0, 1, 1, 1, 0, 0)));
        vq.push_back(vin(1, 1, 1, 1, 2, 1, 1, ex(6'b010000, 0, 0, 0, 0, 1, 1, 0)));
        vq.push_back(vin(1, 1, 1, 1, 2, 1, 1, ex(6'b000000, 0, 0, 0, 0, 0, 1, 0)));
        vq.push_back(vin(1, 1, 1, 1, 2, 1, 1, ex(6'b000100, 1, 2, 0, 0, 1, 1, 0)));
        vq.push_back(vin(1, 1, 1, 1, 2, 1, 1, ex(6'b000010, 0, 0, 0, 0, 1, 1, 1)));
        vq.push_back(vin(1, 1, 1, 1, 2, 1, 1, ex(6'b000000, 0, 0, 0, 0, 0, 1, 1)));
        vq.push_back(vin(1, 1, 1, 1, 2, 1, 1, ex(6'b100000, 0, 0, 1, 1, 1, 1, 1)));
        vq.push_back(vin(1, 1, 1, 1, 2, 1, 1, ex(6'b010000, 0, 0, 0, 0, 1, 2, 1)));
        vq.push_back(vin(1, 1, 1, 1, 2, 1, 1, ex(6'b000000, 0, 0, 0, 0, 0, 2, 1)));
        vq.push_back(vin(1, 1, 1, 1, 2, 1, 1, ex(6'b000100, 1, 2, 0, 0, 1, 2, 1)));
        vq.push_back(vin(1, 1, 1, 1, 2, 1, 1, ex(6'b000010, 0, 0, 0, 0, 1, 2, 2)));
        vq.push_back(vin(1, 0, 1, 0, 2, 0, 0, ex(6'b000000, 0, 0, 0, 0, 0, 2, 2)));

        @(negedge clk);
        foreach (vq[i]) begin
            rst_n = vq[i].rst; a_req = vq[i].areq; a_msg = vq[i].amsg;
            b_req = vq[i].breq; b_msg = vq[i].bmsg;
            to_a_ack = vq[i].aack; to_b_ack = vq[i].back;
            step();
            chk($sformatf("vec%0d", i), cur(), vq[i].exp);
        end

        // timeout on B after an A transfer moved the pointer to B
        do_reset();
        a_req = 1; a_msg = 5; step();
        to_b_ack = 1; step();
        a_req = 0; to_b_ack = 0; step();
        b_req = 1; b_msg = 7; to_b_ack = 1;
        step();
        chk("to_b_gnt", {a_gnt, b_gnt}, 2'b01);
        vc = 0; ec = 0; dc = 0; bad = 0;
        for (int i = 0; i < 30; i++) begin
            vc += int'(to_a_valid);
            ec += int'(b_err);
            dc += int'(b_done);
            if (to_a_valid && to_a_msg != 32'd7) bad++;
            if (b_err) b_req = 0;
            step();
        end
        chk("to_valid_cycles", vc, 16);
        chk("to_err_pulses", ec, 1);
        chk("to_done_pulses", dc, 0);
        chk("to_msg", bad, 0);
        chk("to_b2a", b2a_count, 0);
        a_req = 1; b_req = 1; to_b_ack = 0;
        step();
        chk("to_next_gnt", {a_gnt, b_gnt}, 2'b10);

        // ack arrives only in the 16th SEND cycle
        do_reset();
        b_req = 1; b_msg = 9; to_b_ack = 1;
        step();
        repeat (15) step();
        chk("last_valid", {to_a_valid, to_a_msg}, {1'b1, 32'd9});
        to_a_ack = 1;
        step();
        chk("last_done_err", {b_done, b_err}, 2'b10);
        chk("last_b2a", b2a_count, 1);
        b_req = 0; to_a_ack = 0; to_b_ack = 0;
        step();

        // reset during SEND, with the pointer moved to B beforehand
        do_reset();
        a_req = 1; a_msg = 3; to_b_ack = 1; step();
        step();
        a_req = 0; to_b_ack = 0; step();
        a_req = 1; a_msg = 4; step();
        chk("rst_pre_valid", to_b_valid, 1);
        b_req = 1;
        rst_n = 0;
        #1;
        chk("rst_outputs", cur(), '0);
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            pulses += int'(a_done | a_err | b_done | b_err);
        end
        rst_n = 1;
        step();
        pulses += int'(a_done | a_err | b_done | b_err);
        chk("rst_no_pulse", pulses, 0);
        chk("rst_first_gnt", {a_gnt, b_gnt}, 2'b10);
        a_req = 0; b_req = 0;
        step();

        // 2-bit counter wrap: 1,2,3,0
        k = 0;
        w_a_req = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (w_a_done && k < 4) begin
                wexp = 2'(k + 1);
                chk($sformatf("wrap%0d", k), w_a2b, wexp);
                k++;
                if (k == 4) w_a_req = 0;
            end
        end
        chk("wrap_count", k, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
